// File: rtl/word_entry_ctrl_pkg.sv
// Shared types and sizes for the word entry path.
// Checker and display logic import the same word geometry.
package word_entry_ctrl_pkg;

    localparam int WORD_LEN    = 5;
    localparam int MAX_GUESSES = 6;

    localparam logic [7:0] ASCII_NULL = 8'h00;

    typedef enum logic [1:0] {
        ENTRY  = 2'd0,
        FULL   = 2'd1,
        SUBMIT = 2'd2,
        LOCKED = 2'd3
    } word_ctrl_state_t;

endpackage

// File: rtl/word_entry_ctrl_buffer.sv
// WORD_LEN x 8 letter register file with indexed write and clear.
// The flat word output is the register contents, slot 0 in the low byte.
module word_entry_ctrl_buffer #(
    parameter int WORD_LEN = 5,
    parameter int CNT_W    = $clog2(WORD_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic                  we,
    input  logic [CNT_W-1:0]      idx,
    input  logic [7:0]            wdata,
    input  logic                  clr,
    output logic [8*WORD_LEN-1:0] word
);
    import word_entry_ctrl_pkg::*;

    always_ff @(posedge clk) begin
        if (!nRst || clr) begin
            word <= {WORD_LEN{ASCII_NULL}};
        end else if (we) begin
            for (int i = 0; i < WORD_LEN; i++) begin
                if (idx == CNT_W'(i)) begin
                    word[8*i +: 8] <= wdata;
                end
            end
        end
    end

endmodule

// File: rtl/word_entry_ctrl.sv
// Collects keypad letters into words and hands them to the checker.
// Also counts accepted guesses and locks the game when it ends.
module word_entry_ctrl #(
    parameter int WORD_LEN    = 5,
    parameter int MAX_GUESSES = 6,
    parameter int CNT_W       = $clog2(WORD_LEN + 1),
    parameter int GCNT_W      = $clog2(MAX_GUESSES + 1)
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic                  letter_valid,
    input  logic [7:0]            letter,
    input  logic                  submit_word,
    input  logic                  clear_word,
    input  logic                  game_end,
    input  logic                  word_ack,
    output logic                  word_valid,
    output logic [8*WORD_LEN-1:0] word,
    output logic [CNT_W-1:0]      letter_count,
    output logic [GCNT_W-1:0]     guess_count,
    output logic                  accepting,
    output logic                  err_short,
    output logic                  game_over
);
    import word_entry_ctrl_pkg::*;

    localparam logic [CNT_W-1:0]  LAST_SLOT  = CNT_W'(WORD_LEN - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(WORD_LEN);
    localparam logic [GCNT_W-1:0] LAST_GUESS = GCNT_W'(MAX_GUESSES - 1);

    word_ctrl_state_t state;
    logic             buf_we;
    logic             buf_clr;

    assign accepting = (state == ENTRY) && (letter_count < FULL_CNT);

    // Buffer controls follow the same priority order as the FSM below.
    always_comb begin
        buf_we  = 1'b0;
        buf_clr = 1'b0;
        if (game_end) begin
            buf_clr = 1'b1;
        end else begin
            case (state)
                ENTRY: begin
                    if (clear_word) begin
                        buf_clr = 1'b1;
                    end else if (!submit_word && letter_valid
                                 && letter_count < FULL_CNT) begin
                        buf_we = 1'b1;
                    end
                end
                FULL:    buf_clr = clear_word;
                SUBMIT:  buf_clr = word_ack;
                default: buf_clr = 1'b0;
            endcase
        end
    end

    word_entry_ctrl_buffer #(
        .WORD_LEN (WORD_LEN),
        .CNT_W    (CNT_W)
    ) u_buffer (
        .clk   (clk),
        .nRst  (nRst),
        .we    (buf_we),
        .idx   (letter_count),
        .wdata (letter),
        .clr   (buf_clr),
        .word  (word)
    );

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state        <= ENTRY;
            letter_count <= '0;
            guess_count  <= '0;
            word_valid   <= 1'b0;
            err_short    <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            err_short <= 1'b0;
            if (game_end) begin
                state        <= LOCKED;
                letter_count <= '0;
                word_valid   <= 1'b0;
                game_over    <= 1'b1;
            end else begin
                case (state)
                    ENTRY: begin
                        if (clear_word) begin
                            letter_count <= '0;
                        end else if (submit_word) begin
                            err_short <= 1'b1;
                        end else if (letter_valid) begin
                            letter_count <= letter_count + 1'b1;
                            if (letter_count == LAST_SLOT) begin
                                state <= FULL;
                            end
                        end
                    end
                    FULL: begin
                        if (clear_word) begin
                            letter_count <= '0;
                            state        <= ENTRY;
                        end else if (submit_word) begin
                            state      <= SUBMIT;
                            word_valid <= 1'b1;
                        end
                    end
                    SUBMIT: begin
                        if (word_ack) begin
                            guess_count  <= guess_count + 1'b1;
                            letter_count <= '0;
                            word_valid   <= 1'b0;
                            if (guess_count == LAST_GUESS) begin
                                state     <= LOCKED;
                                game_over <= 1'b1;
                            end else begin
                                state <= ENTRY;
                            end
                        end
                    end
                    default: begin
                        state <= LOCKED;
                    end
                endcase
            end
        end
    end

endmodule
